// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: holds the PC, picks JR/J/branch redirects by priority,
// and buffers one redirect across a stall so it lands on stall release.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchBase,
  input  logic [31:0] BranchOffsetSL2,
  input  logic        Jump,
  input  logic [25:0] JumpIndex,
  input  logic        JumpReg,
  input  logic [31:0] JumpRegTarget,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        FetchValid,
  output logic        Flush,
  output logic        MisalignErr
);

  localparam logic [1:0] BOOT      = 2'd0;
  localparam logic [1:0] RUN       = 2'd1;
  localparam logic [1:0] HOLD      = 2'd2;
  localparam logic [1:0] HOLD_PEND = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pend_tgt;
  logic        pend_vld;
  logic        flush;
  logic        misalign;
  logic        redirect;
  logic [31:0] branch_tgt;
  logic [31:0] tgt;

  assign PCPlus4    = pc + 32'd4;
  assign branch_tgt = BranchBase + BranchOffsetSL2;
  assign redirect   = JumpReg | Jump | BranchTaken;

  // Low two bits are forced to zero so the PC can never go unaligned.
  always_comb begin
    tgt = 32'h0;
    if (JumpReg)          tgt = JumpRegTarget & 32'hFFFF_FFFC;
    else if (Jump)        tgt = {PCPlus4[31:28], JumpIndex, 2'b00};
    else if (BranchTaken) tgt = branch_tgt & 32'hFFFF_FFFC;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state    <= BOOT;
      pc       <= RESET_VECTOR;
      pend_tgt <= 32'h0;
      pend_vld <= 1'b0;
      flush    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      flush    <= 1'b0;
      misalign <= (state != BOOT) && JumpReg && (JumpRegTarget[1:0] != 2'b00);
      case (state)
        BOOT: begin
          state    <= RUN;
          pend_vld <= 1'b0;
        end
        default: begin
          if (!Stall) begin
            // A fresh redirect beats anything buffered during the stall.
            state    <= RUN;
            pend_vld <= 1'b0;
            if (redirect) begin
              pc    <= tgt;
              flush <= 1'b1;
            end else if (state == HOLD_PEND && pend_vld) begin
              pc    <= pend_tgt;
              flush <= 1'b1;
            end else begin
              pc <= PCPlus4;
            end
          end else if (redirect) begin
            pend_tgt <= tgt;
            pend_vld <= 1'b1;
            state    <= HOLD_PEND;
          end else if (state == RUN) begin
            state <= HOLD;
          end
        end
      endcase
    end
  end

  assign PC          = pc;
  assign Flush       = flush;
  assign MisalignErr = misalign;
  assign FetchValid  = (state != BOOT) && !Stall;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-stage program-counter sequencer for the single-issue MIPS datapath. It holds the PC register and forms PC+4. It consumes the word-aligned branch offset produced by the shift-left-by-2 stage and forms the branch target from it. It arbitrates branch, jump and jump-register redirects and stalls, and drives the instruction-memory address plus a one-cycle flush pulse to the IF/ID register. Redirects that arrive during a stall are buffered and applied when the stall releases.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- Clk  input  1  single clock; all state updates on rising edge.
- Rst  input  1  synchronous, active-high reset.
- Stall  input  1  hold PC (hazard unit).
- BranchTaken  input  1  branch resolved taken this cycle.
- BranchBase  input  32  PC+4 of the branch instruction.
- BranchOffsetSL2  input  32  sign-extended offset already shifted left 2.
- Jump  input  1  J/JAL request.
- JumpIndex  input  26  instr[25:0].
- JumpReg  input  1  JR/JALR request.
- JumpRegTarget  input  32  register value.
- PC  output  32  current fetch address.
- PCPlus4  output  32  PC + 4, combinational from PC.
- FetchValid  output  1  PC is a real fetch (not boot bubble, not stalled).
- Flush  output  1  one-cycle pulse: squash the instruction in IF/ID.
- MisalignErr  output  1  one-cycle pulse: JR target had bits [1:0] != 0.

## Operation
- Redirect request this cycle is the highest-priority asserted input: JumpReg > Jump > BranchTaken.
- Targets:
  - JR = {JumpRegTarget[31:2], 2'b00}.
  - J = {PCPlus4[31:28], JumpIndex, 2'b00}.
  - Branch = BranchBase + BranchOffsetSL2, modulo 2^32 (wrap, no overflow flag).
- The pending register holds one target plus a valid bit.
- States:
  - BOOT: entered on Rst. PC = RESET_VECTOR, FetchValid = 0, pending cleared. Always goes to RUN next cycle; redirects in BOOT are ignored.
  - RUN, Stall=0:
    - If a redirect is requested, PC <= target and Flush <= 1.
    - Otherwise PC <= PCPlus4.
    - Stays in RUN.
  - RUN, Stall=1:
    - PC holds.
    - If a redirect is requested, the target is latched into pending and the state goes to HOLD_PEND; otherwise go to HOLD.
  - HOLD:
    - Stall=1 plus a redirect latches pending and goes to HOLD_PEND.
    - Stall=1 with no redirect stays in HOLD.
    - Stall=0 behaves exactly as RUN with Stall=0, then goes to RUN.
  - HOLD_PEND:
    - Stall=1 plus a new redirect overwrites pending (newest wins).
    - Stall=0 plus a new redirect: the new redirect wins and pending is discarded.
    - Stall=0 with no new redirect: PC <= pending target, Flush <= 1, pending cleared.
    - Either Stall=0 case goes to RUN.
- MisalignErr pulses in the cycle after a JR redirect is accepted (applied or latched) with JumpRegTarget[1:0] != 0. The PC is still loaded with the cleared-low-bits target.
- PC[1:0] is always 2'b00.

## Timing
- Reset values: PC = RESET_VECTOR, Flush = 0, MisalignErr = 0, FetchValid = 0, pending valid = 0, state BOOT.
- Rst asserted mid-stall or with pending discards pending and re-enters BOOT on the next edge.
- Redirect latency: request at edge N (Stall=0) gives PC = target and Flush = 1 after edge N. Flush is registered and high exactly one cycle.
- Sequential fetch: PC advances by 4 per edge while in RUN with Stall=0.
- FetchValid = 1 in RUN and in HOLD/HOLD_PEND only when Stall=0. It is 0 in BOOT and whenever Stall=1.
- Pending redirect applies at the first edge where Stall=0, giving one-cycle latency after stall release.
- Wrap: PC = 32'hFFFF_FFFC sequential gives next PC = 32'h0000_0000.

## Test plan
- Reset/boot: Rst high 2 cycles, then low.
  - PC = 0 and FetchValid = 0 for the first cycle after release.
  - PC then steps 0, 4, 8, 12 with FetchValid = 1.
- Branch: at PC = 0x10, BranchTaken = 1, BranchBase = 0x14, BranchOffsetSL2 = 0xFFFF_FFF0.
  - Next PC = 0x04 and Flush = 1 for one cycle.
- Priority: JumpReg (0x400), Jump (index 0x40) and BranchTaken asserted together.
  - PC = 0x400.
  - Then Jump alone at PC = 0x400 gives PC = 0x100.
- Stall with pending: Stall = 1 for 3 cycles at PC = 0x20, BranchTaken to 0x80 in stall cycle 1, Jump to 0x200 in stall cycle 2.
  - PC holds 0x20.
  - After release, PC = 0x200, Flush = 1 once.
- Misaligned JR: JumpRegTarget = 0x103.
  - PC = 0x100 and MisalignErr = 1 for one cycle.
- Reset mid-pending: latch a branch during stall, then assert Rst.
  - PC = RESET_VECTOR, no Flush, and the pending target is never applied.
